// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared constants, FSM state type and helpers for the fetch stage
// Purpose: XLEN, reset PC, decode NOP, fetch FSM encoding, skid packet type, PC alignment.
package fetch_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // One fetched word together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Redirect targets are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory request/ack bus
// Purpose: groups the imem handshake.
// Signals: imem_req/imem_addr (fetch -> mem), imem_ack/imem_rdata (mem -> fetch).
// Modports: master = fetch controller, slave = instruction memory.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_ctrl_if_id_reg.sv
// rtl/fetch_ctrl_if_id_reg.sv - IF/ID pipeline register with load/hold/flush
// Purpose: holds the instruction handed to decode.
// Ports: clk, rst (sync, active-high); i_load/i_flush controls; i_instr/i_pc data in;
//        o_instr/o_pc/o_pc_plus4/o_valid towards decode. Neither control -> hold.
module fetch_ctrl_if_id_reg
  import fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  // Flush wins over load: a redirect must never let a word through.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc + XLEN'(4);
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - RV32I fetch sequencer against a variable-latency imem
// Purpose: next-PC register, imem request handshake, one-entry skid buffer, IF/ID register.
// Ports: clk, rst (sync, active-high); PCSrcE/PCTargetE redirect from execute;
//        stall_d from decode; imem (master modport); InstrD/PCD/PCPlus4D/valid_d to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            stall_d,
  fetch_ctrl_if.master    imem,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            valid_d
);

  fetch_state_e    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc_f, r_addr_q;
  logic [XLEN-1:0] w_pc_nxt, w_addr_nxt, w_target, w_pc_plus4;
  fetch_pkt_t      r_skid, w_ifid_in;
  logic            w_req, w_ack, w_load, w_flush, w_skid_load;

  assign w_req      = (r_state == REQ) || (r_state == DRAIN);
  assign w_ack      = imem.imem_ack && w_req;   // acks outside a request are ignored
  assign w_target   = align_pc(PCTargetE);
  assign w_pc_plus4 = r_pc_f + XLEN'(4);

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_addr_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  w_state_nxt = REQ;
      // A redirect without ack leaves a stale request in flight that must be drained.
      REQ: begin
        if (PCSrcE)                w_state_nxt = w_ack ? REQ : DRAIN;
        else if (w_ack && stall_d) w_state_nxt = HOLD;
      end
      DRAIN: if (!PCSrcE && w_ack)  w_state_nxt = REQ;
      HOLD:  if (PCSrcE || !stall_d) w_state_nxt = REQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    w_pc_nxt    = r_pc_f;
    w_addr_nxt  = r_addr_q;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    w_skid_load = 1'b0;
    w_ifid_in   = '{instr: imem.imem_rdata, pc: r_pc_f};
    case (r_state)
      IDLE: begin
        if (PCSrcE) begin
          w_flush    = 1'b1;
          w_pc_nxt   = w_target;
          w_addr_nxt = w_target;
        end
      end
      REQ: begin
        if (PCSrcE) begin
          // Any word acked this cycle belongs to the old path and is dropped.
          w_flush  = 1'b1;
          w_pc_nxt = w_target;
          if (w_ack) w_addr_nxt = w_target;
        end else if (w_ack && !stall_d) begin
          w_load     = 1'b1;
          w_pc_nxt   = w_pc_plus4;
          w_addr_nxt = w_pc_plus4;
        end else if (w_ack) begin
          // Park the word; addr_q catches up with pc_f when HOLD releases.
          w_skid_load = 1'b1;
          w_pc_nxt    = w_pc_plus4;
        end else if (!stall_d) begin
          w_flush = 1'b1;
        end
      end
      DRAIN: begin
        w_flush = 1'b1;
        if (PCSrcE)     w_pc_nxt   = w_target;
        else if (w_ack) w_addr_nxt = r_pc_f;
      end
      HOLD: begin
        if (PCSrcE) begin
          w_flush    = 1'b1;
          w_pc_nxt   = w_target;
          w_addr_nxt = w_target;
        end else if (!stall_d) begin
          w_load     = 1'b1;
          w_ifid_in  = r_skid;
          w_addr_nxt = r_pc_f;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f   <= RESET_PC;
      r_addr_q <= RESET_PC;
      r_skid   <= '0;
    end else begin
      r_pc_f   <= w_pc_nxt;
      r_addr_q <= w_addr_nxt;
      if (w_skid_load) r_skid <= '{instr: imem.imem_rdata, pc: r_pc_f};
    end
  end

  fetch_ctrl_if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (w_ifid_in.instr),
    .i_pc       (w_ifid_in.pc),
    .o_instr    (InstrD),
    .o_pc       (PCD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (valid_d)
  );

endmodule
